// File: rtl/pattern_matcher_pkg.sv
// Shared types and constants for the streaming pattern matcher.
// The wildcard character is only honoured when PATTERN_MATCHER_WILDCARD_EN is defined.
package pattern_matcher_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    typedef logic [7:0] char_t;

    localparam char_t WILDCARD_CHAR = 8'h3F;

endpackage

// File: rtl/pm_char_cmp.sv
// Single-position comparator between one window character and one pattern character.
// With PATTERN_MATCHER_WILDCARD_EN defined, a '?' pattern character matches anything.
module pm_char_cmp
    import pattern_matcher_pkg::*;
(
    input  char_t i_win_char,
    input  char_t i_pat_char,
    input  logic  i_en,
    output logic  o_hit
);

    logic w_eq;

`ifdef PATTERN_MATCHER_WILDCARD_EN
    assign w_eq = (i_pat_char == WILDCARD_CHAR) || (i_win_char == i_pat_char);
`else
    assign w_eq = (i_win_char == i_pat_char);
`endif

    // Positions beyond the pattern length never veto a match.
    assign o_hit = !i_en || w_eq;

endmodule

// File: rtl/pattern_matcher.sv
// Streaming detector: loads a pattern of up to MAX_LEN chars, then reports every
// (overlapping) match with its start index. Wildcard support: PATTERN_MATCHER_WILDCARD_EN.
module pattern_matcher
    import pattern_matcher_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int IDX_W   = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  char_t            load_char,
    input  logic             load_last,
    input  logic             in_valid,
    input  char_t            in_char,
    output logic             ready,
    output logic             match,
    output logic [IDX_W-1:0] match_pos,
    output logic [CNT_W-1:0] match_cnt,
    output logic             load_err
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int PTR_W = $clog2(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    state_t             r_state;
    state_t             w_state_nxt;
    char_t              r_pat    [MAX_LEN];
    char_t              r_window [MAX_LEN];
    char_t              w_shift  [MAX_LEN];
    char_t              w_win_sel[MAX_LEN];
    logic [MAX_LEN-1:0] w_en;
    logic [MAX_LEN-1:0] w_pos_hit;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_fill;
    logic [LEN_W-1:0]   w_fill_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_match;
    logic [IDX_W-1:0]   r_match_pos;
    logic [CNT_W-1:0]   r_match_cnt;
    logic               r_load_err;
    logic               w_enter_load;
    logic               w_overflow;
    logic               w_accept;
    logic               w_hit;

    assign ready     = (r_state == RUN);
    assign match     = r_match;
    assign match_pos = r_match_pos;
    assign match_cnt = r_match_cnt;
    assign load_err  = r_load_err;

    // A pattern write always wins over a stream character arriving in the same cycle.
    assign w_accept     = in_valid && ready && !load_valid;
    assign w_enter_load = load_valid && (r_state != LOAD);
    assign w_overflow   = load_valid && (r_len == LEN_MAX);

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: default assigned first so no path through the case infers a latch.
        w_state_nxt = r_state;
        case (r_state)
            IDLE, RUN: if (load_valid) w_state_nxt = load_last ? RUN : LOAD;
            LOAD:      if (load_valid && load_last)
                           w_state_nxt = (r_load_err || w_overflow) ? IDLE : RUN;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // Post-shift window view: the match is judged on the window including the new char.
    always_comb begin
        w_shift[0] = in_char;
        for (int i = 1; i < MAX_LEN; i++) w_shift[i] = r_window[i-1];
    end

    assign w_fill_nxt = (r_fill == LEN_MAX) ? r_fill : r_fill + LEN_W'(1);

    always_comb begin
        for (int k = 0; k < MAX_LEN; k++) begin
            w_win_sel[k] = '0;
            w_en[k]      = (LEN_W'(k) < r_len);
            if (w_en[k]) w_win_sel[k] = w_shift[PTR_W'(int'(r_len) - 1 - k)];
        end
    end

    for (genvar k = 0; k < MAX_LEN; k++) begin : g_cmp
        pm_char_cmp u_cmp (
            .i_win_char (w_win_sel[k]),
            .i_pat_char (r_pat[k]),
            .i_en       (w_en[k]),
            .o_hit      (w_pos_hit[k])
        );
    end

    assign w_hit = (r_len != '0) && (w_fill_nxt >= r_len) && (&w_pos_hit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the pattern and window arrays are reset too, so a reset fully forgets the pattern.
            for (int i = 0; i < MAX_LEN; i++) begin
                r_pat[i]    <= '0;
                r_window[i] <= '0;
            end
            r_len       <= '0;
            r_fill      <= '0;
            r_idx       <= '0;
            r_match     <= 1'b0;
            r_match_pos <= '0;
            r_match_cnt <= '0;
            r_load_err  <= 1'b0;
        end else begin
            r_match <= 1'b0;
            if (w_enter_load) begin
                r_pat[0]    <= load_char;
                r_len       <= LEN_W'(1);
                r_fill      <= '0;
                r_idx       <= '0;
                r_match_cnt <= '0;
                r_load_err  <= 1'b0;
            end else if (r_state == LOAD && load_valid) begin
                if (w_overflow) begin
                    r_load_err <= 1'b1;
                end else begin
                    r_pat[PTR_W'(r_len)] <= load_char;
                    r_len                <= r_len + LEN_W'(1);
                end
            end else if (w_accept) begin
                for (int i = 0; i < MAX_LEN; i++) r_window[i] <= w_shift[i];
                r_fill <= w_fill_nxt;
                r_idx  <= r_idx + IDX_W'(1);
                if (w_hit) begin
                    r_match     <= 1'b1;
                    r_match_pos <= r_idx - (IDX_W'(r_len) - IDX_W'(1));
                    if (!(&r_match_cnt)) r_match_cnt <= r_match_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pattern_matcher.sv
// Directed bench for pattern_matcher: table of pattern/stream cases plus
// hand-written overflow, saturation and mid-stream reset sequences.
module tb_pattern_matcher;
    import pattern_matcher_pkg::*;

    localparam int MAX_LEN = 8;
    localparam int IDX_W   = 16;
    localparam int CNT_W   = 8;
    localparam int NVEC    = 7;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             load_valid = 1'b0;
    char_t            load_char  = '0;
    logic             load_last  = 1'b0;
    logic             in_valid   = 1'b0;
    char_t            in_char    = '0;
    logic             ready;
    logic             match;
    logic [IDX_W-1:0] match_pos;
    logic [CNT_W-1:0] match_cnt;
    logic             load_err;

    pattern_matcher #(.MAX_LEN(MAX_LEN), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_char  (load_char),
        .load_last  (load_last),
        .in_valid   (in_valid),
        .in_char    (in_char),
        .ready      (ready),
        .match      (match),
        .match_pos  (match_pos),
        .match_cnt  (match_cnt),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int mpos[$];
    int mcyc[$];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (rst && match) begin
            mpos.push_back(int'(match_pos));
            mcyc.push_back(cyc);
        end
    end

    typedef struct {
        int n;
        int pos0;
        int pos1;
        int gap;
        int cnt;
    } exp_t;

    string pats[NVEC];
    string strs[NVEC];
    exp_t  exps[NVEC];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_pattern(input string p);
        for (int i = 0; i < p.len(); i++) begin
            @(negedge clk);
            load_valid = 1'b1;
            load_char  = p[i];
            load_last  = (i == p.len() - 1);
        end
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
        mpos.delete();
        mcyc.delete();
    endtask

    task automatic send_stream(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_char  = s[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_repeat(input char_t c, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_char  = c;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        string main_s;
        main_s = "AABABA__JUSTMONIKA__CDEDE";

        pats[0] = "ABA";      strs[0] = main_s;     exps[0] = '{2, 1, 3, 2, 2};
        pats[1] = "MONIKA";   strs[1] = main_s;     exps[1] = '{1, 12, 0, 0, 1};
        pats[2] = "DE";       strs[2] = main_s;     exps[2] = '{2, 21, 23, 2, 2};
        pats[3] = "ABCDEFGH"; strs[3] = "ABCDEFGH"; exps[3] = '{1, 0, 0, 0, 1};
`ifdef PATTERN_MATCHER_WILDCARD_EN
        pats[4] = "D?D";      strs[4] = "CDEDE";    exps[4] = '{1, 1, 0, 0, 1};
`else
        pats[4] = "D?D";      strs[4] = "CDEDE";    exps[4] = '{0, 0, 0, 0, 0};
`endif
        pats[5] = "AB";       strs[5] = "XAB";      exps[5] = '{1, 1, 0, 0, 1};
        // Old window holds "..AB"; a fresh load must not let it complete "BA".
        pats[6] = "BA";       strs[6] = "A";        exps[6] = '{0, 0, 0, 0, 0};

        #12;
        check("reset ready", ready, 0);
        check("reset match", match, 0);
        check("reset match_pos", match_pos, 0);
        check("reset match_cnt", match_cnt, 0);
        check("reset load_err", load_err, 0);
        @(negedge clk);
        rst = 1'b1;

        send_stream("ABA");
        check("idle ignores stream", mpos.size(), 0);
        check("idle ready", ready, 0);

        for (int v = 0; v < NVEC; v++) begin
            load_pattern(pats[v]);
            check($sformatf("v%0d ready", v), ready, 1);
            check($sformatf("v%0d load_err", v), load_err, 0);
            check($sformatf("v%0d cnt after load", v), match_cnt, 0);
            send_stream(strs[v]);
            check($sformatf("v%0d n_match", v), mpos.size(), exps[v].n);
            if (mpos.size() >= 1 && exps[v].n >= 1)
                check($sformatf("v%0d pos0", v), mpos[0], exps[v].pos0);
            if (mpos.size() >= 2 && exps[v].n >= 2) begin
                check($sformatf("v%0d pos1", v), mpos[1], exps[v].pos1);
                check($sformatf("v%0d gap", v), mcyc[1] - mcyc[0], exps[v].gap);
            end
            check($sformatf("v%0d match_cnt", v), match_cnt, exps[v].cnt);
        end

        // Overflow: nine chars into an eight-deep pattern.
        load_pattern("ABCDEFGHI");
        check("ovf load_err", load_err, 1);
        check("ovf ready", ready, 0);
        send_stream("ABCDEFGH");
        check("ovf no match", mpos.size(), 0);
        check("ovf match_cnt", match_cnt, 0);
        check("ovf err sticky", load_err, 1);
        load_pattern("AB");
        check("reload clears err", load_err, 0);
        check("reload ready", ready, 1);

        // Saturation: 300 'A's against "AA" gives 299 matches, counter pins at 255.
        load_pattern("AA");
        send_repeat(8'h41, 300);
        check("sat n_match", mpos.size(), 299);
        check("sat match_cnt", match_cnt, 255);
        if (mpos.size() == 299) check("sat last pos", mpos[298], 298);

        // Asynchronous reset in the middle of a stream.
        load_pattern("ABA");
        send_stream("AABA");
        check("pre-rst n_match", mpos.size(), 1);
        check("pre-rst cnt", match_cnt, 1);
        @(negedge clk);
        in_valid = 1'b1;
        in_char  = 8'h42;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst ready", ready, 0);
        check("rst match", match, 0);
        check("rst match_pos", match_pos, 0);
        check("rst match_cnt", match_cnt, 0);
        check("rst load_err", load_err, 0);
        @(negedge clk);
        rst = 1'b1;
        mpos.delete();
        send_stream("ABABA");
        check("post-rst no match", mpos.size(), 0);
        check("post-rst ready", ready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
